// File: rtl/psu_pkg.sv
// Shared types and constants for the PSU emulation blocks.
package psu_pkg;
  localparam int ADC_FRAME_BITS = 16;
  localparam int ADC_DATA_WIDTH = 12;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    TAIL
  } adc_state_t;

  // One-cycle status pulses raised at frame boundaries.
  typedef struct packed {
    logic done;
    logic abort;
    logic underrun;
  } adc_evt_t;
endpackage

// File: rtl/spi_sync_edge.sv
// Synchronizes one asynchronous SPI pin and emits single-cycle rise/fall pulses.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   level;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;
endmodule

// File: rtl/adc_spi_responder.sv
// Emulated 12-bit serial ADC: answers a 16-clock SPI read with leading zeros
// plus a sample taken from a one-deep valid/ready hold buffer.
module adc_spi_responder
  import psu_pkg::*;
#(
  parameter int DATA_WIDTH  = ADC_DATA_WIDTH,
  parameter int LEAD_ZEROS  = ADC_FRAME_BITS - ADC_DATA_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sck,
  input  logic                  cs,
  output logic                  dout,
  input  logic [DATA_WIDTH-1:0] sample_in,
  input  logic                  sample_valid,
  output logic                  sample_ready,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  frame_abort,
  output logic                  underrun
);
  localparam int FRAME_BITS = LEAD_ZEROS + DATA_WIDTH;
  localparam int CNT_W      = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BITS - 1);

  logic [1:0] rise_v, fall_v;
  logic       sck_rise, sck_fall, cs_rise, cs_fall;

  // Index 0 carries sck, index 1 carries cs; both pins idle high.
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync [1:0] (
    .clk  (clk),
    .rst  (rst),
    .pin  ({cs, sck}),
    .rise (rise_v),
    .fall (fall_v)
  );

  assign sck_rise = rise_v[0];
  assign sck_fall = fall_v[0];
  assign cs_rise  = rise_v[1];
  assign cs_fall  = fall_v[1];

  adc_state_t                state_q, state_d;
  logic [FRAME_BITS-1:0]     shreg_q, shreg_d;
  logic [CNT_W-1:0]          rise_cnt_q, rise_cnt_d;
  logic [CNT_W-1:0]          bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0]     hold_reg_q, hold_reg_d;
  logic                      hold_full_q, hold_full_d;
  logic [DATA_WIDTH-1:0]     last_sent_q, last_sent_d;
  adc_evt_t                  evt_q, evt_d;
  logic                      hs;

  assign hs = sample_valid & ~hold_full_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      rise_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      hold_reg_q  <= '0;
      hold_full_q <= 1'b0;
      last_sent_q <= '0;
      evt_q       <= '0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      rise_cnt_q  <= rise_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      hold_reg_q  <= hold_reg_d;
      hold_full_q <= hold_full_d;
      last_sent_q <= last_sent_d;
      evt_q       <= evt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    rise_cnt_d  = rise_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    last_sent_d = last_sent_q;
    evt_d       = '0;
    // A handshake only occurs while empty, so it never collides with a consume.
    hold_reg_d  = hs ? sample_in : hold_reg_q;
    hold_full_d = hold_full_q | hs;

    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          if (hold_full_q) begin
            shreg_d     = {{LEAD_ZEROS{1'b0}}, hold_reg_q};
            last_sent_d = hold_reg_q;
            hold_full_d = 1'b0;
          end else begin
            shreg_d        = {{LEAD_ZEROS{1'b0}}, last_sent_q};
            evt_d.underrun = 1'b1;
          end
          rise_cnt_d = '0;
          bit_cnt_d  = '0;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          evt_d.abort = 1'b1;
          state_d     = IDLE;
        end else begin
          if (sck_rise && rise_cnt_q != CNT_MAX) begin
            rise_cnt_d = rise_cnt_q + CNT_W'(1);
            if (rise_cnt_q == CNT_LAST) state_d = TAIL;
          end
          // The falling edge before the first rise leaves the first bit in place.
          if (sck_fall && rise_cnt_q != '0 && bit_cnt_q != CNT_MAX) begin
            shreg_d   = {shreg_q[FRAME_BITS-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      TAIL: begin
        if (cs_rise) begin
          evt_d.done = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign dout         = (state_q == SHIFT) & shreg_q[FRAME_BITS-1];
  assign busy         = (state_q != IDLE);
  assign sample_ready = ~hold_full_q;
  assign frame_done   = evt_q.done;
  assign frame_abort  = evt_q.abort;
  assign underrun     = evt_q.underrun;
endmodule
